// File: rtl/cache_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_core_if                                                   |
// | Purpose  : Bundles the cache client port (request/response) and the AXI4   |
// |            master port (aw/w/b/ar/r) into one interface.                   |
// |            slave  : view taken by cache_core.                              |
// |            master : view taken by the surrounding system (client + memory).|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cache_core_if;
  // client request / response
  logic         request_valid;
  logic         request_ready;
  logic [23:0]  request_bits_addr;
  logic [511:0] request_bits_data;
  logic [63:0]  request_bits_mask;
  logic         request_bits_lock;
  logic [3:0]   request_bits_port;
  logic         response_valid;
  logic         response_ready;
  logic [511:0] response_bits_data;
  logic         response_bits_success;
  // AXI write address
  logic         mem_interface_aw_valid;
  logic         mem_interface_aw_ready;
  logic [32:0]  mem_interface_aw_addr;
  logic [1:0]   mem_interface_aw_burst;
  logic [3:0]   mem_interface_aw_cache;
  logic [5:0]   mem_interface_aw_id;
  logic [3:0]   mem_interface_aw_len;
  logic         mem_interface_aw_lock;
  logic [2:0]   mem_interface_aw_prot;
  logic [3:0]   mem_interface_aw_qos;
  logic [3:0]   mem_interface_aw_region;
  logic [2:0]   mem_interface_aw_size;
  // AXI read address
  logic         mem_interface_ar_valid;
  logic         mem_interface_ar_ready;
  logic [32:0]  mem_interface_ar_addr;
  logic [1:0]   mem_interface_ar_burst;
  logic [3:0]   mem_interface_ar_cache;
  logic [5:0]   mem_interface_ar_id;
  logic [3:0]   mem_interface_ar_len;
  logic         mem_interface_ar_lock;
  logic [2:0]   mem_interface_ar_prot;
  logic [3:0]   mem_interface_ar_qos;
  logic [3:0]   mem_interface_ar_region;
  logic [2:0]   mem_interface_ar_size;
  // AXI write data
  logic         mem_interface_w_valid;
  logic         mem_interface_w_ready;
  logic [511:0] mem_interface_w_data;
  logic         mem_interface_w_last;
  logic [63:0]  mem_interface_w_strb;
  // AXI read data
  logic         mem_interface_r_valid;
  logic         mem_interface_r_ready;
  logic [511:0] mem_interface_r_data;
  logic         mem_interface_r_last;
  logic [1:0]   mem_interface_r_resp;
  logic [5:0]   mem_interface_r_id;
  // AXI write response
  logic         mem_interface_b_valid;
  logic         mem_interface_b_ready;
  logic [5:0]   mem_interface_b_id;
  logic [1:0]   mem_interface_b_resp;

  modport slave (
    input  request_valid, request_bits_addr, request_bits_data, request_bits_mask,
           request_bits_lock, request_bits_port, response_ready,
           mem_interface_aw_ready, mem_interface_ar_ready, mem_interface_w_ready,
           mem_interface_r_valid, mem_interface_r_data, mem_interface_r_last,
           mem_interface_r_resp, mem_interface_r_id,
           mem_interface_b_valid, mem_interface_b_id, mem_interface_b_resp,
    output request_ready, response_valid, response_bits_data, response_bits_success,
           mem_interface_aw_valid, mem_interface_aw_addr, mem_interface_aw_burst,
           mem_interface_aw_cache, mem_interface_aw_id, mem_interface_aw_len,
           mem_interface_aw_lock, mem_interface_aw_prot, mem_interface_aw_qos,
           mem_interface_aw_region, mem_interface_aw_size,
           mem_interface_ar_valid, mem_interface_ar_addr, mem_interface_ar_burst,
           mem_interface_ar_cache, mem_interface_ar_id, mem_interface_ar_len,
           mem_interface_ar_lock, mem_interface_ar_prot, mem_interface_ar_qos,
           mem_interface_ar_region, mem_interface_ar_size,
           mem_interface_w_valid, mem_interface_w_data, mem_interface_w_last,
           mem_interface_w_strb, mem_interface_r_ready, mem_interface_b_ready
  );

  modport master (
    output request_valid, request_bits_addr, request_bits_data, request_bits_mask,
           request_bits_lock, request_bits_port, response_ready,
           mem_interface_aw_ready, mem_interface_ar_ready, mem_interface_w_ready,
           mem_interface_r_valid, mem_interface_r_data, mem_interface_r_last,
           mem_interface_r_resp, mem_interface_r_id,
           mem_interface_b_valid, mem_interface_b_id, mem_interface_b_resp,
    input  request_ready, response_valid, response_bits_data, response_bits_success,
           mem_interface_aw_valid, mem_interface_aw_addr, mem_interface_aw_burst,
           mem_interface_aw_cache, mem_interface_aw_id, mem_interface_aw_len,
           mem_interface_aw_lock, mem_interface_aw_prot, mem_interface_aw_qos,
           mem_interface_aw_region, mem_interface_aw_size,
           mem_interface_ar_valid, mem_interface_ar_addr, mem_interface_ar_burst,
           mem_interface_ar_cache, mem_interface_ar_id, mem_interface_ar_len,
           mem_interface_ar_lock, mem_interface_ar_prot, mem_interface_ar_qos,
           mem_interface_ar_region, mem_interface_ar_size,
           mem_interface_w_valid, mem_interface_w_data, mem_interface_w_last,
           mem_interface_w_strb, mem_interface_r_ready, mem_interface_b_ready
  );
endinterface
`default_nettype wire

// File: rtl/cache_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_core                                                      |
// | Purpose  : Direct-mapped, write-back, write-allocate cache, 64 B lines,    |
// |            single outstanding request, single-beat AXI4 refill/evict.      |
// | Ports    : clock  - clock                                                  |
// |            reset  - asynchronous active-low reset                          |
// |            io     - cache_core_if.slave (client req/resp + AXI master)     |
// |            io_perf_hits/io_perf_misses - lookup counters (CACHE_PERF_EN)   |
// | Config   : `define CACHE_PERF_EN adds the hit/miss counters and ports.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_core #(
  parameter int INDEX_BITS = 10
) (
  input  wire logic   clock,
  input  wire logic   reset,
  cache_core_if.slave io
`ifdef CACHE_PERF_EN
  ,
  output logic [31:0] io_perf_hits,
  output logic [31:0] io_perf_misses
`endif
);

  localparam int TAG_BITS = 18 - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    WB_B   = 3'd3,
    AR     = 3'd4,
    R      = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [17:0]           r_line_addr;     // request address bits [23:6]
  logic [511:0]          r_wdata;
  logic [63:0]           r_mask;
  logic [511:0]          r_resp_data;
  logic                  r_success;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [SETS-1:0]       r_valid;
  logic [SETS-1:0]       r_dirty;
  logic [TAG_BITS-1:0]   r_tag      [SETS];
  logic [511:0]          r_data_mem [SETS];

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic [TAG_BITS-1:0]   w_set_tag;
  logic [511:0]          w_set_line;
  logic                  w_hit;
  logic                  w_is_write;
  logic [511:0]          w_hit_line;
  logic [511:0]          w_fill_line;
  logic                  w_mem_we;
  logic [511:0]          w_mem_wdata;
  logic                  w_unused;

  function automatic logic [511:0] merge_bytes(input logic [511:0] old_line,
                                               input logic [511:0] new_data,
                                               input logic [63:0]  mask);
    logic [511:0] merged;
    merged = old_line;
    for (int i = 0; i < 64; i++) begin
      if (mask[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return merged;
  endfunction

  assign w_index     = r_line_addr[INDEX_BITS-1:0];
  assign w_req_tag   = r_line_addr[17:INDEX_BITS];
  // The set entry is not rewritten until the refill lands in R, so the victim
  // tag/line read here stay stable through WB and WB_B.
  assign w_set_tag   = r_tag[w_index];
  assign w_set_line  = r_data_mem[w_index];
  assign w_hit       = r_valid[w_index] && (w_set_tag == w_req_tag);
  assign w_is_write  = |r_mask;
  assign w_hit_line  = merge_bytes(w_set_line, r_wdata, r_mask);
  assign w_fill_line = merge_bytes(io.mem_interface_r_data, r_wdata, r_mask);

  assign w_mem_we    = ((r_state == LOOKUP) && w_hit && w_is_write) ||
                       ((r_state == R) && io.mem_interface_r_valid);
  assign w_mem_wdata = (r_state == LOOKUP) ? w_hit_line : w_fill_line;

  // Reserved request fields, low address bits and single-beat AXI ids/last
  assign w_unused = ^{io.request_bits_lock, io.request_bits_port, io.request_bits_addr[5:0],
                      io.mem_interface_r_last, io.mem_interface_r_id, io.mem_interface_b_id};

  // ---------------------------------------------------------------- outputs
  assign io.request_ready         = (r_state == IDLE) && reset;
  assign io.response_valid        = (r_state == RESP);
  assign io.response_bits_data    = r_resp_data;
  assign io.response_bits_success = r_success;

  assign io.mem_interface_aw_valid  = (r_state == WB) && !r_aw_done;
  assign io.mem_interface_aw_addr   = {9'd0, w_set_tag, w_index, 6'd0};
  assign io.mem_interface_aw_burst  = 2'b01;
  assign io.mem_interface_aw_cache  = 4'd0;
  assign io.mem_interface_aw_id     = 6'd0;
  assign io.mem_interface_aw_len    = 4'd0;
  assign io.mem_interface_aw_lock   = 1'b0;
  assign io.mem_interface_aw_prot   = 3'd0;
  assign io.mem_interface_aw_qos    = 4'd0;
  assign io.mem_interface_aw_region = 4'd0;
  assign io.mem_interface_aw_size   = 3'b110;

  assign io.mem_interface_w_valid   = (r_state == WB) && !r_w_done;
  assign io.mem_interface_w_data    = w_set_line;
  assign io.mem_interface_w_last    = 1'b1;
  assign io.mem_interface_w_strb    = {64{1'b1}};
  assign io.mem_interface_b_ready   = (r_state == WB_B);

  assign io.mem_interface_ar_valid  = (r_state == AR);
  assign io.mem_interface_ar_addr   = {9'd0, r_line_addr, 6'd0};
  assign io.mem_interface_ar_burst  = 2'b01;
  assign io.mem_interface_ar_cache  = 4'd0;
  assign io.mem_interface_ar_id     = 6'd0;
  assign io.mem_interface_ar_len    = 4'd0;
  assign io.mem_interface_ar_lock   = 1'b0;
  assign io.mem_interface_ar_prot   = 3'd0;
  assign io.mem_interface_ar_qos    = 4'd0;
  assign io.mem_interface_ar_region = 4'd0;
  assign io.mem_interface_ar_size   = 3'b110;
  assign io.mem_interface_r_ready   = (r_state == R);

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (io.request_valid) w_next_state = LOOKUP;
      LOOKUP: begin
        if (w_hit)                                w_next_state = RESP;
        else if (r_valid[w_index] && r_dirty[w_index]) w_next_state = WB;
        else                                      w_next_state = AR;
      end
      // A channel counts as done if it completed earlier or completes now.
      WB:     if ((r_aw_done || io.mem_interface_aw_ready) &&
                  (r_w_done  || io.mem_interface_w_ready)) w_next_state = WB_B;
      WB_B:   if (io.mem_interface_b_valid)  w_next_state = AR;
      AR:     if (io.mem_interface_ar_ready) w_next_state = R;
      R:      if (io.mem_interface_r_valid)  w_next_state = RESP;
      RESP:   if (io.response_ready)         w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_line_addr <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_resp_data <= '0;
      r_success   <= 1'b1;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_valid     <= '0;
      r_dirty     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (io.request_valid) begin
            r_line_addr <= io.request_bits_addr[23:6];
            r_wdata     <= io.request_bits_data;
            r_mask      <= io.request_bits_mask;
            r_success   <= 1'b1;
          end
        end
        LOOKUP: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (w_hit) begin
            r_resp_data <= w_hit_line;
            if (w_is_write) r_dirty[w_index] <= 1'b1;
          end
        end
        WB: begin
          if (io.mem_interface_aw_ready) r_aw_done <= 1'b1;
          if (io.mem_interface_w_ready)  r_w_done  <= 1'b1;
        end
        WB_B: begin
          if (io.mem_interface_b_valid && (io.mem_interface_b_resp != 2'b00)) r_success <= 1'b0;
        end
        R: begin
          if (io.mem_interface_r_valid) begin
            r_resp_data      <= w_fill_line;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= w_is_write;
            if (io.mem_interface_r_resp != 2'b00) r_success <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; they are qualified by r_valid.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_data_mem[w_index] <= w_mem_wdata;
    if ((r_state == R) && io.mem_interface_r_valid) r_tag[w_index] <= w_req_tag;
  end

`ifdef CACHE_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_perf_hits   <= 32'd0;
      io_perf_misses <= 32'd0;
    end else if (r_state == LOOKUP) begin
      if (w_hit) io_perf_hits   <= io_perf_hits + 32'd1;
      else       io_perf_misses <= io_perf_misses + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_core                                                   |
// | Purpose  : Self-checking bench for cache_core: directed scenarios plus     |
// |            randomized accesses against a set-level cache/memory model.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cache_core;
  localparam int INDEX_BITS = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_core_if bus();

`ifdef CACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  cache_core #(.INDEX_BITS(INDEX_BITS)) dut (
    .clock (clk),
    .reset (rst_n),
    .io    (bus)
`ifdef CACHE_PERF_EN
    ,
    .io_perf_hits   (perf_hits),
    .io_perf_misses (perf_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: backing memory keyed by line address, and per-set state.
  logic [511:0] mem_model [int];
  bit           m_valid [1024];
  bit           m_dirty [1024];
  logic [7:0]   m_tag   [1024];
  logic [511:0] m_line  [1024];
  int           n_hits   = 0;
  int           n_misses = 0;

  localparam logic [30:0] AXI_CONST = {2'b01, 3'b110, 26'd0};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] mem_get(input logic [23:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return {16{32'(a) ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [511:0] merge(input logic [511:0] old_line,
                                         input logic [511:0] data, input logic [63:0] mask);
    logic [511:0] v;
    v = old_line;
    for (int b = 0; b < 64; b++) if (mask[b]) v[b*8 +: 8] = data[b*8 +: 8];
    return v;
  endfunction

  function automatic logic [30:0] aw_fields();
    return {bus.mem_interface_aw_burst, bus.mem_interface_aw_size, bus.mem_interface_aw_len,
            bus.mem_interface_aw_id, bus.mem_interface_aw_cache, bus.mem_interface_aw_lock,
            bus.mem_interface_aw_prot, bus.mem_interface_aw_qos, bus.mem_interface_aw_region};
  endfunction

  function automatic logic [30:0] ar_fields();
    return {bus.mem_interface_ar_burst, bus.mem_interface_ar_size, bus.mem_interface_ar_len,
            bus.mem_interface_ar_id, bus.mem_interface_ar_cache, bus.mem_interface_ar_lock,
            bus.mem_interface_ar_prot, bus.mem_interface_ar_qos, bus.mem_interface_ar_region};
  endfunction

  task automatic idle_inputs();
    bus.request_valid = 0; bus.response_ready = 0;
    bus.mem_interface_aw_ready = 0; bus.mem_interface_w_ready = 0; bus.mem_interface_ar_ready = 0;
    bus.mem_interface_r_valid = 0; bus.mem_interface_b_valid = 0;
  endtask

  // One complete client access, acting as client and AXI memory at once.
  task automatic access(input string name, input logic [23:0] addr, input logic [511:0] wdata,
                        input logic [63:0] mask, input bit stall, input bit err_r, input bit err_b);
    logic [9:0] idx; logic [7:0] tag; logic [23:0] laddr, vaddr;
    bit hit, is_wr, exp_wb, exp_ok;
    logic [511:0] vline, fill, exp_line, w_snap, resp_snap;
    logic [32:0] aw_snap, ar_snap;
    int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt, first_it;
    bit aw_fire, w_fire, ar_fire, r_fire, b_fire;
    bit aw_seen, w_seen, ar_seen, resp_seen, b_issued, r_issued, done;

    idx = addr[15:6]; tag = addr[23:16]; laddr = {addr[23:6], 6'd0};
    hit    = m_valid[idx] && (m_tag[idx] == tag);
    is_wr  = (mask != 0);
    exp_wb = !hit && m_valid[idx] && m_dirty[idx];
    vaddr  = {m_tag[idx], idx, 6'd0};
    vline  = m_line[idx];
    fill   = mem_get(laddr);
    exp_line = merge(hit ? m_line[idx] : fill, wdata, mask);
    exp_ok = !((!hit && err_r) || (exp_wb && err_b));
    {aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt} = '0;
    {aw_fire, w_fire, ar_fire, r_fire, b_fire} = '0;
    {aw_seen, w_seen, ar_seen, resp_seen, b_issued, r_issued, done} = '0;
    first_it = -1;
    w_snap = '0; resp_snap = '0; aw_snap = '0; ar_snap = '0;

    @(negedge clk);
    bus.request_valid = 1; bus.request_bits_addr = addr;
    bus.request_bits_data = wdata; bus.request_bits_mask = mask;
    bus.request_bits_lock = 1'($urandom); bus.request_bits_port = 4'($urandom);
    chk({name, ".req_ready"}, bus.request_ready, 1);
    @(posedge clk);

    for (int it = 0; it < 300 && !done; it++) begin
      @(negedge clk);
      if (it == 0) begin
        // Scrambled inputs must not leak into the latched request.
        bus.request_valid = 0; bus.request_bits_addr = 24'($urandom);
        bus.request_bits_data = rand_line(); bus.request_bits_mask = {$urandom, $urandom};
      end
      if (aw_fire) begin aw_cnt++; aw_fire = 0; end
      if (w_fire)  begin w_cnt++;  w_fire  = 0; end
      if (ar_fire) begin ar_cnt++; ar_fire = 0; end
      if (b_fire)  begin b_cnt++;  b_fire  = 0; bus.mem_interface_b_valid = 0; end
      if (r_fire)  begin r_cnt++;  r_fire  = 0; bus.mem_interface_r_valid = 0; end
      chk({name, ".busy_ready"}, bus.request_ready, 0);

      if (bus.mem_interface_aw_valid) begin
        if (!aw_seen) begin
          aw_seen = 1; aw_snap = bus.mem_interface_aw_addr;
          chk({name, ".aw_addr"}, bus.mem_interface_aw_addr, {9'd0, vaddr});
          chk({name, ".aw_fields"}, aw_fields(), AXI_CONST);
        end else chk({name, ".aw_stable"}, bus.mem_interface_aw_addr, aw_snap);
        bus.mem_interface_aw_ready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        aw_fire = bus.mem_interface_aw_ready;
      end else bus.mem_interface_aw_ready = 0;

      if (bus.mem_interface_w_valid) begin
        if (!w_seen) begin
          w_seen = 1; w_snap = bus.mem_interface_w_data;
          chk({name, ".w_data"}, bus.mem_interface_w_data, vline);
          chk({name, ".w_strb_last"}, {bus.mem_interface_w_strb, bus.mem_interface_w_last}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
        end else chk({name, ".w_stable"}, bus.mem_interface_w_data, w_snap);
        bus.mem_interface_w_ready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        w_fire = bus.mem_interface_w_ready;
      end else bus.mem_interface_w_ready = 0;

      if (aw_cnt == 1 && w_cnt == 1 && !b_issued) begin
        b_issued = 1; bus.mem_interface_b_valid = 1;
        bus.mem_interface_b_resp = err_b ? 2'b10 : 2'b00;
      end
      if (bus.mem_interface_b_valid && bus.mem_interface_b_ready) b_fire = 1;

      if (bus.mem_interface_ar_valid) begin
        if (!ar_seen) begin
          ar_seen = 1; ar_snap = bus.mem_interface_ar_addr;
          chk({name, ".ar_addr"}, bus.mem_interface_ar_addr, {9'd0, laddr});
          chk({name, ".ar_fields"}, ar_fields(), AXI_CONST);
        end else chk({name, ".ar_stable"}, bus.mem_interface_ar_addr, ar_snap);
        bus.mem_interface_ar_ready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        ar_fire = bus.mem_interface_ar_ready;
      end else bus.mem_interface_ar_ready = 0;

      if (ar_cnt == 1 && !r_issued) begin
        r_issued = 1; bus.mem_interface_r_valid = 1; bus.mem_interface_r_data = fill;
        bus.mem_interface_r_resp = err_r ? 2'b10 : 2'b00;
      end
      if (bus.mem_interface_r_valid && bus.mem_interface_r_ready) r_fire = 1;

      if (bus.response_valid) begin
        if (!resp_seen) begin
          resp_seen = 1; first_it = it; resp_snap = bus.response_bits_data;
          chk({name, ".resp_data"}, bus.response_bits_data, exp_line);
          chk({name, ".resp_success"}, bus.response_bits_success, exp_ok);
        end else chk({name, ".resp_stable"}, bus.response_bits_data, resp_snap);
        bus.response_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        done = bus.response_ready;
      end else bus.response_ready = stall ? 1'b0 : 1'b1;
    end

    chk({name, ".completed"}, done, 1);
    chk({name, ".aw_count"}, aw_cnt, exp_wb ? 1 : 0);
    chk({name, ".w_count"}, w_cnt, exp_wb ? 1 : 0);
    chk({name, ".ar_count"}, ar_cnt, hit ? 0 : 1);
    if (hit && !stall) chk({name, ".hit_latency"}, first_it, 1);

    @(posedge clk); #1;
    idle_inputs();

    if (exp_wb) mem_model[int'(vaddr)] = vline;
    m_dirty[idx] = hit ? (m_dirty[idx] | is_wr) : is_wr;
    m_valid[idx] = 1; m_tag[idx] = tag; m_line[idx] = exp_line;
    if (hit) n_hits++; else n_misses++;
  endtask

  initial begin
    bit seen;
    logic [23:0] a;
    logic [63:0] mk;
    bus.request_bits_addr = '0; bus.request_bits_data = '0; bus.request_bits_mask = '0;
    bus.request_bits_lock = 0; bus.request_bits_port = '0;
    bus.mem_interface_r_data = '0; bus.mem_interface_r_last = 1; bus.mem_interface_r_resp = '0;
    bus.mem_interface_r_id = '0; bus.mem_interface_b_id = '0; bus.mem_interface_b_resp = '0;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req_ready", bus.request_ready, 0);
    chk("rst.valids", {bus.response_valid, bus.mem_interface_aw_valid, bus.mem_interface_w_valid,
                       bus.mem_interface_ar_valid, bus.mem_interface_r_ready, bus.mem_interface_b_ready}, 6'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rst.release_ready", bus.request_ready, 1);
`ifdef CACHE_PERF_EN
    chk("rst.perf", {perf_hits, perf_misses}, 64'd0);
`endif

    // Directed scenarios
    mem_model[32'h00000] = 512'd1;
    mem_model[32'h00040] = 512'd3;
    mem_model[32'h10040] = 512'd4;
    access("rd0_cold",  24'h000000, '0,     '0,  0, 0, 0);
    access("wr40_miss", 24'h000040, 512'd2, '1,  0, 0, 0);
    access("rd0_hit",   24'h000000, '0,     '0,  0, 0, 0);
    access("rd40_hit",  24'h000040, '0,     '0,  0, 0, 0);
    access("rd_wb",     24'h010040, '0,     '0,  0, 0, 0);
    chk("wb.mem40", mem_model[32'h40], 512'd2);
    access("wr_hit",    24'h010040, 512'd5, '1,  0, 0, 0);
    access("rd_hit5",   24'h010040, '0,     '0,  0, 0, 0);
    access("stall_wb",  24'h020040, rand_line(), 64'h00FF_0000_F0F0_0001, 1, 0, 0);
    access("err_rb",    24'h030040, '0,     '0,  0, 1, 1);

    // Randomized accesses over a small index/tag space to force conflicts
    for (int n = 0; n < 60; n++) begin
      a  = {6'd0, 2'($urandom_range(0, 3)), 8'd0, 2'($urandom_range(0, 3)), 6'($urandom)};
      mk = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
      access("rand", a, rand_line(), mk, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
`ifdef CACHE_PERF_EN
    chk("perf.hits", perf_hits, 32'(n_hits));
    chk("perf.misses", perf_misses, 32'(n_misses));
`endif

    // Reset while a refill is outstanding: transaction is abandoned, state cleared
    @(negedge clk);
    bus.request_valid = 1; bus.request_bits_addr = {8'h7F, 10'd5, 6'd0}; bus.request_bits_mask = '0;
    @(posedge clk);
    @(negedge clk); bus.request_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_interface_ar_valid;
    end
    chk("abort.ar_seen", seen, 1);
    rst_n = 0; #1;
    chk("abort.req_ready", bus.request_ready, 0);
    chk("abort.valids", {bus.response_valid, bus.mem_interface_ar_valid, bus.mem_interface_r_ready}, 3'd0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 1024; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    n_hits = 0; n_misses = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort.no_resp", bus.response_valid, 0);
    end
    access("post_rst_miss", 24'h010040, '0, '0, 0, 0, 0);
    access("post_rst_hit",  24'h010040, '0, '0, 0, 0, 0);
`ifdef CACHE_PERF_EN
    chk("perf.post_rst", {perf_hits, perf_misses}, {32'd1, 32'd1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
